// File: rtl/flash_read_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM flash read port between two requesters.
// One read in flight at a time; a readdatavalid timeout forces completion and sets a sticky error.
module flash_read_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned ADDR_W         = 23
) (
    input  logic              CLK50MHZ,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    output logic [31:0]       rd_data,
    output logic              rd_valid0,
    output logic              rd_valid1,
    output logic              busy,
    output logic              timeout_err,
    output logic              flash_mem_read,
    output logic [ADDR_W-1:0] flash_mem_address,
    output logic [3:0]        flash_mem_byteenable,
    input  logic              flash_mem_waitrequest,
    input  logic              flash_mem_readdatavalid,
    input  logic [31:0]       flash_mem_readdata
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_DATA,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              grant_q, grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       rd_data_q, rd_data_d;
    logic              timeout_err_q, timeout_err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rd_valid0_q, rd_valid0_d;
    logic              rd_valid1_q, rd_valid1_d;
    logic              read_q, read_d;
    logic              busy_q, busy_d;
    logic [3:0]        be_q, be_d;
    logic              winner;

    // State and output registers; outputs are precomputed from the next state
    always_ff @(posedge CLK50MHZ or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            last_grant_q  <= 1'b1;
            grant_q       <= 1'b0;
            addr_q        <= '0;
            rd_data_q     <= '0;
            timeout_err_q <= 1'b0;
            cnt_q         <= '0;
            rd_valid0_q   <= 1'b0;
            rd_valid1_q   <= 1'b0;
            read_q        <= 1'b0;
            busy_q        <= 1'b0;
            be_q          <= 4'h0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            grant_q       <= grant_d;
            addr_q        <= addr_d;
            rd_data_q     <= rd_data_d;
            timeout_err_q <= timeout_err_d;
            cnt_q         <= cnt_d;
            rd_valid0_q   <= rd_valid0_d;
            rd_valid1_q   <= rd_valid1_d;
            read_q        <= read_d;
            busy_q        <= busy_d;
            be_q          <= be_d;
        end
    end

    // Next-state and registered-output decode
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        grant_d       = grant_q;
        addr_d        = addr_q;
        rd_data_d     = rd_data_q;
        timeout_err_d = timeout_err_q;
        cnt_d         = cnt_q;
        winner        = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    // With both requesting, the side not served last time wins
                    winner       = (req0 && req1) ? ~last_grant_q : req1;
                    grant_d      = winner;
                    last_grant_d = winner;
                    addr_d       = winner ? addr1 : addr0;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!flash_mem_waitrequest) begin
                    cnt_d   = '0;
                    state_d = S_WAIT_DATA;
                end
            end
            S_WAIT_DATA: begin
                if (flash_mem_readdatavalid) begin
                    rd_data_d = flash_mem_readdata;
                    state_d   = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    rd_data_d     = '0;
                    timeout_err_d = 1'b1;
                    state_d       = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        read_d      = (state_d == S_ISSUE);
        be_d        = read_d ? 4'hF : 4'h0;
        busy_d      = (state_d != S_IDLE);
        rd_valid0_d = (state_d == S_DONE) && !grant_d;
        rd_valid1_d = (state_d == S_DONE) && grant_d;
    end

    assign rd_data              = rd_data_q;
    assign rd_valid0            = rd_valid0_q;
    assign rd_valid1            = rd_valid1_q;
    assign busy                 = busy_q;
    assign timeout_err          = timeout_err_q;
    assign flash_mem_read       = read_q;
    assign flash_mem_address    = addr_q;
    assign flash_mem_byteenable = be_q;

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Bench for flash_read_arbiter: behavioural Avalon flash model plus an expected-transaction queue.
module tb_flash_read_arbiter;

    localparam int unsigned AW = 23;

    logic          clk;
    logic          reset;
    logic          req0, req1;
    logic [AW-1:0] addr0, addr1;
    logic [31:0]   rd_data;
    logic          rd_valid0, rd_valid1, busy, timeout_err;
    logic          fm_read;
    logic [AW-1:0] fm_addr;
    logic [3:0]    fm_be;
    logic          waitreq, rdv;
    logic [31:0]   rdata;

    flash_read_arbiter #(.TIMEOUT_CYCLES(16), .ADDR_W(AW)) dut (
        .CLK50MHZ               (clk),
        .reset                  (reset),
        .req0                   (req0),
        .req1                   (req1),
        .addr0                  (addr0),
        .addr1                  (addr1),
        .rd_data                (rd_data),
        .rd_valid0              (rd_valid0),
        .rd_valid1              (rd_valid1),
        .busy                   (busy),
        .timeout_err            (timeout_err),
        .flash_mem_read         (fm_read),
        .flash_mem_address      (fm_addr),
        .flash_mem_byteenable   (fm_be),
        .flash_mem_waitrequest  (waitreq),
        .flash_mem_readdatavalid(rdv),
        .flash_mem_readdata     (rdata)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        int          id;
        logic [AW-1:0] addr;
    } exp_t;

    exp_t          exp_q[$];
    logic [AW-1:0] acc_q[$];

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc = 0, acc_cyc = 0, n_acc = 0, n_rd_cyc = 0;
    int          n_v0 = 0, n_v1 = 0, n_bad_be = 0, n_addr_chg = 0;
    int          stall_cfg = 0, st_cnt = 0, lat_cfg = 1, cd = 0;
    int          stray_req = 0, stray_done = 0;
    bit          noresp = 0, pend = 0, prev_read = 0;
    logic [AW-1:0] pend_addr, last_rd_addr;
    logic [31:0] data_base = 32'h1357_0000;

    // Flash model: stall, accept, then return data_base+addr after lat_cfg cycles
    always @(negedge clk) begin
        rdv = 1'b0;
        if (stray_done != stray_req) begin
            rdv   = 1'b1;
            rdata = 32'hFFFF_FFFF;
            stray_done++;
        end else if (pend) begin
            if (cd <= 1) begin
                rdv   = 1'b1;
                rdata = data_base + {9'b0, pend_addr};
                pend  = 0;
            end else begin
                cd--;
            end
        end
        if (fm_read) begin
            if (st_cnt < stall_cfg) begin
                waitreq = 1'b1;
                st_cnt++;
            end else begin
                waitreq = 1'b0;
                st_cnt  = 0;
                acc_q.push_back(fm_addr);
                n_acc++;
                acc_cyc = cyc + 1;
                if (!noresp) begin
                    pend      = 1;
                    cd        = lat_cfg;
                    pend_addr = fm_addr;
                end
            end
        end else begin
            waitreq = 1'b0;
        end
    end

    // Bus monitor: strobe cycles, stability of address/byteenable, pulse counts
    always @(posedge clk) begin
        cyc++;
        if (rd_valid0) n_v0++;
        if (rd_valid1) n_v1++;
        if (fm_read) begin
            n_rd_cyc++;
            if (fm_be !== 4'hF) n_bad_be++;
            if (prev_read && fm_addr !== last_rd_addr) n_addr_chg++;
            last_rd_addr = fm_addr;
        end else if (fm_be !== 4'h0) begin
            n_bad_be++;
        end
        prev_read = fm_read;
    end

    task automatic do_reset();
        reset = 1'b1;
        req0  = 1'b0;
        req1  = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_valid(output int id, output logic [31:0] d, output bit ok);
        ok = 0;
        id = -1;
        d  = '0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (rd_valid0 || rd_valid1) begin
                ok = 1;
                id = rd_valid1 ? 1 : 0;
                d  = rd_data;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req0  = 1'b0;
        req1  = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({rd_data, rd_valid0, rd_valid1, busy, timeout_err, fm_read, fm_addr, fm_be} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: rd_data=%h v0=%b v1=%b busy=%b terr=%b read=%b addr=%h be=%h, required all 0",
                     rd_data, rd_valid0, rd_valid1, busy, timeout_err, fm_read, fm_addr, fm_be);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        int id; logic [31:0] d; bit ok; int v0, v1, acc; logic [AW-1:0] a;
        do_reset();
        data_base = 32'hA5A5_1134;
        lat_cfg = 2; stall_cfg = 0; noresp = 0;
        v0 = n_v0; v1 = n_v1; acc = n_acc;
        req0 = 1'b1; addr0 = 23'h000100;
        exp_q.push_back('{0, 23'h000100});
        wait_valid(id, d, ok);
        req0 = 1'b0;
        exp_q.pop_front();
        n_tests++;
        if (!ok || id !== 0 || d !== 32'hA5A5_1234) begin
            n_fail++;
            $display("FAIL single_read: ok=%0d id=%0d data=%h, required ok=1 id=0 data=a5a51234", ok, id, d);
        end
        repeat (3) @(negedge clk);
        a = (acc_q.size() > 0) ? acc_q.pop_front() : 'x;
        n_tests++;
        if (n_acc - acc != 1 || a !== 23'h000100) begin
            n_fail++;
            $display("FAIL single_accept: accepts=%0d addr=%h, required 1 at 000100", n_acc - acc, a);
        end
        n_tests++;
        if (n_v0 - v0 != 1 || n_v1 - v1 != 0) begin
            n_fail++;
            $display("FAIL single_pulses: v0=%0d v1=%0d, required 1 and 0", n_v0 - v0, n_v1 - v1);
        end
    endtask

    task automatic test_round_robin();
        int id; logic [31:0] d; bit ok; exp_t e; logic [AW-1:0] a;
        data_base = 32'h0C0D_0000; lat_cfg = 1; stall_cfg = 0; noresp = 0;
        reset = 1'b1;
        req0 = 1'b1; req1 = 1'b1;
        addr0 = 23'h000111; addr1 = 23'h000222;
        exp_q.push_back('{0, 23'h000111});
        exp_q.push_back('{1, 23'h000222});
        exp_q.push_back('{0, 23'h000333});
        exp_q.push_back('{1, 23'h000444});
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_valid(id, d, ok);
            if (k == 0) addr0 = 23'h000333;
            if (k == 1) addr1 = 23'h000444;
            if (k == 3) begin req0 = 1'b0; req1 = 1'b0; end
            e = exp_q.pop_front();
            a = (acc_q.size() > 0) ? acc_q.pop_front() : 'x;
            n_tests++;
            if (!ok || id !== e.id || a !== e.addr || d !== data_base + {9'b0, e.addr}) begin
                n_fail++;
                $display("FAIL rr_txn%0d: ok=%0d id=%0d addr=%h data=%h, required id=%0d addr=%h data=%h",
                         k, ok, id, a, d, e.id, e.addr, data_base + {9'b0, e.addr});
            end
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || acc_q.size() != 0) begin
            n_fail++;
            $display("FAIL rr_idle: busy=%b extra_accepts=%0d, required 0 and 0", busy, acc_q.size());
        end
    endtask

    task automatic test_waitrequest();
        int id; logic [31:0] d; bit ok; int rc, acc, v1, chg, bbe; logic [AW-1:0] a;
        do_reset();
        data_base = 32'h5000_0000; lat_cfg = 1; stall_cfg = 5; noresp = 0;
        rc = n_rd_cyc; acc = n_acc; v1 = n_v1; chg = n_addr_chg; bbe = n_bad_be;
        req1 = 1'b1; addr1 = 23'h07ABCD;
        exp_q.push_back('{1, 23'h07ABCD});
        wait_valid(id, d, ok);
        req1 = 1'b0;
        stall_cfg = 0;
        exp_q.pop_front();
        repeat (3) @(negedge clk);
        a = (acc_q.size() > 0) ? acc_q.pop_front() : 'x;
        n_tests++;
        if (!ok || id !== 1 || d !== 32'h5000_0000 + 32'h0007_ABCD || a !== 23'h07ABCD) begin
            n_fail++;
            $display("FAIL stall_read: ok=%0d id=%0d data=%h addr=%h, required id=1 data=5007abcd addr=07abcd", ok, id, d, a);
        end
        n_tests++;
        if (n_rd_cyc - rc != 6 || n_acc - acc != 1 || n_v1 - v1 != 1) begin
            n_fail++;
            $display("FAIL stall_counts: read_cycles=%0d accepts=%0d pulses=%0d, required 6 1 1",
                     n_rd_cyc - rc, n_acc - acc, n_v1 - v1);
        end
        n_tests++;
        if (n_addr_chg - chg != 0 || n_bad_be - bbe != 0) begin
            n_fail++;
            $display("FAIL stall_stable: addr_changes=%0d bad_be=%0d, required 0 0", n_addr_chg - chg, n_bad_be - bbe);
        end
    endtask

    task automatic test_timeout();
        int id; logic [31:0] d; bit ok; int wait_len; logic [AW-1:0] a;
        do_reset();
        data_base = 32'h2222_0000; lat_cfg = 1; stall_cfg = 0; noresp = 0;
        req0 = 1'b1; addr0 = 23'h000010;
        wait_valid(id, d, ok);
        req0 = 1'b0;
        a = (acc_q.size() > 0) ? acc_q.pop_front() : 'x;
        n_tests++;
        if (!ok || id !== 0 || d !== 32'h2222_0010 || timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL pre_timeout_read: ok=%0d id=%0d data=%h terr=%b, required id=0 data=22220010 terr=0", ok, id, d, timeout_err);
        end
        @(negedge clk);
        noresp = 1;
        req1 = 1'b1; addr1 = 23'h000020;
        wait_valid(id, d, ok);
        wait_len = cyc - acc_cyc;
        req1 = 1'b0;
        noresp = 0;
        a = (acc_q.size() > 0) ? acc_q.pop_front() : 'x;
        n_tests++;
        if (!ok || id !== 1 || d !== 32'h0 || wait_len != 16 || a !== 23'h000020) begin
            n_fail++;
            $display("FAIL timeout_read: ok=%0d id=%0d data=%h wait=%0d addr=%h, required id=1 data=0 wait=16 addr=000020",
                     ok, id, d, wait_len, a);
        end
        n_tests++;
        if (timeout_err !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_err_set: got %b, required 1", timeout_err);
        end
        @(negedge clk);
        req0 = 1'b1; addr0 = 23'h000030;
        wait_valid(id, d, ok);
        req0 = 1'b0;
        a = (acc_q.size() > 0) ? acc_q.pop_front() : 'x;
        n_tests++;
        if (!ok || id !== 0 || d !== 32'h2222_0030 || timeout_err !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_sticky: ok=%0d id=%0d data=%h terr=%b, required id=0 data=22220030 terr=1", ok, id, d, timeout_err);
        end
    endtask

    task automatic test_stray_valid();
        int v0, v1;
        repeat (2) @(negedge clk);
        v0 = n_v0; v1 = n_v1;
        stray_req++;
        repeat (4) @(negedge clk);
        n_tests++;
        if (n_v0 != v0 || n_v1 != v1 || rd_data !== 32'h2222_0030 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stray_valid: pulses=%0d/%0d rd_data=%h busy=%b, required 0/0 rd_data=22220030 busy=0",
                     n_v0 - v0, n_v1 - v1, rd_data, busy);
        end
    endtask

    task automatic test_reset_midflight();
        int id; logic [31:0] d; bit ok; int acc, v0, n; logic [AW-1:0] a;
        do_reset();
        data_base = 32'h6600_0000; lat_cfg = 1; stall_cfg = 0; noresp = 1;
        acc = n_acc; v0 = n_v0;
        req0 = 1'b1; addr0 = 23'h000055;
        n = 0;
        while (n_acc == acc && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if (n_acc - acc != 1 || busy !== 1'b1 || fm_read !== 1'b0) begin
            n_fail++;
            $display("FAIL midflight_setup: accepts=%0d busy=%b read=%b, required 1 1 0", n_acc - acc, busy, fm_read);
        end
        reset = 1'b1;
        req0 = 1'b0;
        #1;
        n_tests++;
        if (busy !== 1'b0 || fm_read !== 1'b0 || rd_valid0 !== 1'b0 || fm_be !== 4'h0) begin
            n_fail++;
            $display("FAIL midflight_reset: busy=%b read=%b v0=%b be=%h, required 0 0 0 0", busy, fm_read, rd_valid0, fm_be);
        end
        @(negedge clk);
        reset = 1'b0;
        noresp = 0;
        a = (acc_q.size() > 0) ? acc_q.pop_front() : 'x;
        @(negedge clk);
        req0 = 1'b1; addr0 = 23'h000066;
        wait_valid(id, d, ok);
        req0 = 1'b0;
        a = (acc_q.size() > 0) ? acc_q.pop_front() : 'x;
        repeat (2) @(negedge clk);
        n_tests++;
        if (!ok || id !== 0 || d !== 32'h6600_0066 || a !== 23'h000066 || n_v0 - v0 != 1 || timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_read: ok=%0d id=%0d data=%h addr=%h pulses=%0d terr=%b, required id=0 data=66000066 addr=000066 pulses=1 terr=0",
                     ok, id, d, a, n_v0 - v0, timeout_err);
        end
    endtask

    initial begin
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        addr0 = '0; addr1 = '0;
        waitreq = 1'b0; rdv = 1'b0; rdata = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_waitrequest();
        test_timeout();
        test_stray_valid();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
